// File: rtl/xor_descrambler_pkg.sv
// Shared constants and lock-state encoding for the 1 + x^4 + x^7 descrambler.
package xor_descrambler_pkg;

   localparam int unsigned TAP_A  = 4;
   localparam int unsigned TAP_B  = 7;
   localparam int unsigned HIST_W = 7;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

endpackage

// File: rtl/xor_descrambler_descramble_byte.sv
// Combinational byte descrambler: applies d[n] = s[n] ^ s[n-4] ^ s[n-7] to all
// 8 bits at once and produces the history after shifting the byte in.
module descramble_byte
   import xor_descrambler_pkg::*;
(
   input  logic [HIST_W-1:0] hist,
   input  logic [7:0]        in_data,
   output logic [7:0]        out_bits,
   output logic [HIST_W-1:0] hist_next
);

   // Time-ordered window: ext[0] is the oldest history bit, ext[HIST_W] is in_data[0].
   logic [HIST_W+7:0] ext;

   // Lay the history and the new byte out in arrival order.
   always_comb begin
      ext = '0;
      for (int m = 0; m < HIST_W; m++) begin
         ext[HIST_W-1-m] = hist[m];
      end
      ext[HIST_W +: 8] = in_data;
   end

   // Each output bit XORs the received bit with the two tapped earlier bits.
   always_comb begin
      out_bits = '0;
      for (int i = 0; i < 8; i++) begin
         out_bits[i] = ext[i+HIST_W] ^ ext[i+HIST_W-TAP_A] ^ ext[i+HIST_W-TAP_B];
      end
   end

   // Most recent received bit (in_data[7]) lands in hist_next[0].
   always_comb begin
      hist_next = '0;
      for (int m = 0; m < HIST_W; m++) begin
         hist_next[m] = in_data[7-m];
      end
   end

endmodule

// File: rtl/xor_descrambler.sv
// Byte-wide self-synchronizing descrambler with valid/ready handshakes, a
// registered output stage, lock tracking and an emitted-byte counter.
module xor_descrambler
   import xor_descrambler_pkg::*;
#(
   parameter bit DROP_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        locked,
   output logic [15:0] byte_count
);

   lock_state_e       state_q, state_d;
   logic [HIST_W-1:0] hist_q, hist_d, hist_next;
   logic [7:0]        out_data_q, out_data_d, desc_bits;
   logic              out_valid_q, out_valid_d;
   logic [15:0]       byte_count_q, byte_count_d;
   logic              accept, out_hs;

   descramble_byte u_descramble_byte (
      .hist      (hist_q),
      .in_data   (in_data),
      .out_bits  (desc_bits),
      .hist_next (hist_next)
   );

   // Handshake decode; in_ready stays combinational so a draining output can refill.
   always_comb begin
      in_ready = !out_valid_q || out_ready;
      accept   = in_valid && in_ready;
      out_hs   = out_valid_q && out_ready;
   end

   // Next-state: flush beats any transfer; a dropped first byte still seeds history.
   always_comb begin
      state_d      = state_q;
      hist_d       = hist_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      byte_count_d = byte_count_q;
      if (flush) begin
         state_d      = UNLOCKED;
         hist_d       = '0;
         out_valid_d  = 1'b0;
         byte_count_d = '0;
      end else begin
         if (out_hs) begin
            byte_count_d = byte_count_q + 16'd1;
         end
         if (accept) begin
            hist_d      = hist_next;
            out_data_d  = desc_bits;
            state_d     = LOCKED;
            out_valid_d = !((state_q == UNLOCKED) && DROP_FIRST);
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State, history, output and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= UNLOCKED;
         hist_q       <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         byte_count_q <= '0;
      end else begin
         state_q      <= state_d;
         hist_q       <= hist_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         byte_count_q <= byte_count_d;
      end
   end

   // Output mapping.
   always_comb begin
      out_data   = out_data_q;
      out_valid  = out_valid_q;
      locked     = (state_q == LOCKED);
      byte_count = byte_count_q;
   end

endmodule

// File: tb/tb_xor_descrambler.sv
// Self-checking bench for xor_descrambler: directed corner cases plus a
// randomized scrambler-to-descrambler loopback with random backpressure.
module tb_xor_descrambler;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic [7:0]  in_data, out_data;
   logic        in_valid, in_ready, out_valid, out_ready, locked;
   logic [15:0] byte_count;
   logic [7:0]  d_in_data, d_out_data;
   logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_locked;
   logic [15:0] d_byte_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   xor_descrambler #(.DROP_FIRST(1'b0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .locked     (locked),
      .byte_count (byte_count)
   );

   xor_descrambler #(.DROP_FIRST(1'b1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_data    (d_in_data),
      .in_valid   (d_in_valid),
      .in_ready   (d_in_ready),
      .out_data   (d_out_data),
      .out_valid  (d_out_valid),
      .out_ready  (d_out_ready),
      .locked     (d_locked),
      .byte_count (d_byte_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset       = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_data     = 8'h00;
      out_ready   = 1'b1;
      d_in_valid  = 1'b0;
      d_in_data   = 8'h00;
      d_out_ready = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Scramble random source bytes with s[n] = d[n] ^ s[n-4] ^ s[n-7] from zero history,
   // push them through dut0 and expect the source bytes back in order.
   // mode 1: in_valid always high, out_ready low for cycles 1..3; mode 0: all random.
   task automatic run_stream(input int n, input int mode);
      logic [7:0] src[$];
      logic [7:0] scr[$];
      bit         sb[$];
      int         sent, got, cyc;
      logic [7:0] held;
      bit         hold;
      for (int k = 0; k < n; k++) begin
         logic [7:0] d, s;
         d = 8'($urandom);
         for (int i = 0; i < 8; i++) begin
            int p;
            bit b;
            p = sb.size();
            b = d[i] ^ ((p >= 4) ? sb[p-4] : 1'b0) ^ ((p >= 7) ? sb[p-7] : 1'b0);
            sb.push_back(b);
            s[i] = b;
         end
         src.push_back(d);
         scr.push_back(s);
      end
      sent = 0;
      got  = 0;
      cyc  = 0;
      while ((sent < n || got < n) && cyc < n * 20 + 100) begin
         in_valid  = (sent < n) && (mode == 1 || $urandom_range(0, 3) != 0);
         in_data   = in_valid ? scr[sent] : 8'($urandom);
         out_ready = (mode == 1) ? !(cyc >= 1 && cyc <= 3) : ($urandom_range(0, 2) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (got < n) check("loop_data", {24'h0, out_data}, {24'h0, src[got]});
            else check("extra_out", 32'd1, 32'd0);
            got++;
         end
         hold = 1'b0;
         if (out_valid && !out_ready) begin
            check("bp_in_ready", {31'h0, in_ready}, 32'd0);
            held = out_data;
            hold = 1'b1;
         end
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
         if (hold) check("bp_hold", {24'h0, out_data}, {24'h0, held});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_count", got, n);
      check("stream_byte_count", {16'h0, byte_count}, n & 32'hFFFF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      apply_reset();
      // Reset values.
      check("rst_in_ready", {31'h0, in_ready}, 32'd1);
      check("rst_out_data", {24'h0, out_data}, 32'h00);
      check("rst_out_valid", {31'h0, out_valid}, 32'd0);
      check("rst_locked", {31'h0, locked}, 32'd0);
      check("rst_byte_count", {16'h0, byte_count}, 32'd0);

      // Zero history, first byte emitted.
      in_valid = 1'b1;
      in_data  = 8'h11;
      step();
      check("zh_first_valid", {31'h0, out_valid}, 32'd1);
      check("zh_first_data", {24'h0, out_data}, 32'h81);
      check("zh_locked", {31'h0, locked}, 32'd1);
      in_data = 8'h00;
      step();
      check("zh_second_data", {24'h0, out_data}, 32'h09);
      in_valid = 1'b0;
      step();
      check("zh_byte_count", {16'h0, byte_count}, 32'd2);
      check("zh_drained", {31'h0, out_valid}, 32'd0);

      // Drop-first instance.
      apply_reset();
      d_in_valid = 1'b1;
      d_in_data  = 8'h11;
      step();
      check("df_first_dropped", {31'h0, d_out_valid}, 32'd0);
      check("df_locked", {31'h0, d_locked}, 32'd1);
      d_in_data = 8'h00;
      step();
      check("df_second_valid", {31'h0, d_out_valid}, 32'd1);
      check("df_second_data", {24'h0, d_out_data}, 32'h09);
      d_in_valid = 1'b0;
      step();
      check("df_byte_count", {16'h0, d_byte_count}, 32'd1);

      // Backpressure with continuous input, then random loopback.
      apply_reset();
      run_stream(8, 1);
      apply_reset();
      run_stream(256, 0);

      // Flush while holding valid output, with a simultaneous accept.
      apply_reset();
      in_valid = 1'b1;
      in_data  = 8'h3C;
      step();
      check("fl_pre_valid", {31'h0, out_valid}, 32'd1);
      flush    = 1'b1;
      in_data  = 8'h55;
      #1;
      check("fl_in_ready", {31'h0, in_ready}, 32'd1);
      step();
      flush = 1'b0;
      check("fl_out_valid", {31'h0, out_valid}, 32'd0);
      check("fl_locked", {31'h0, locked}, 32'd0);
      check("fl_byte_count", {16'h0, byte_count}, 32'd0);
      in_data = 8'h11;
      step();
      check("fl_restart_data", {24'h0, out_data}, 32'h81);
      in_valid = 1'b0;
      step();

      // Async reset mid-burst.
      apply_reset();
      in_valid = 1'b1;
      in_data  = 8'h3C;
      step();
      in_data = 8'hA5;
      step();
      step();
      out_ready = 1'b0;
      step();
      check("ar_pre_count", {16'h0, byte_count}, 32'd2);
      reset = 1'b1;
      #1;
      check("ar_in_ready", {31'h0, in_ready}, 32'd1);
      check("ar_out_data", {24'h0, out_data}, 32'h00);
      check("ar_out_valid", {31'h0, out_valid}, 32'd0);
      check("ar_locked", {31'h0, locked}, 32'd0);
      check("ar_byte_count", {16'h0, byte_count}, 32'd0);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      in_data   = 8'h11;
      step();
      check("ar_restart_data", {24'h0, out_data}, 32'h81);
      in_valid = 1'b0;
      step();

      // Counter wrap.
      apply_reset();
      force dut0.byte_count_q = 16'hFFFF;
      #1;
      release dut0.byte_count_q;
      #1;
      check("wrap_preload", {16'h0, byte_count}, 32'hFFFF);
      in_valid = 1'b1;
      in_data  = 8'h11;
      step();
      in_valid = 1'b0;
      step();
      check("wrap_byte_count", {16'h0, byte_count}, 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xor_descrambler.md
# xor_descrambler

Byte-wide self-synchronizing descrambler for the ALU/IO datapath, using the polynomial 1 + x^4 + x^7 built from XOR taps. It consumes a valid/ready stream of scrambled bytes and produces the descrambled byte stream one cycle later through a registered output stage. A small lock state machine tracks whether the 7-bit history is filled from real data, and can discard the first output byte. It sits on the receive side, downstream of the serial/byte framer and upstream of the consumer.

## Interface
- `DROP_FIRST`, 1: when 1, the first byte accepted after reset or flush is consumed but not emitted.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `flush`  input  1  synchronous clear of history, lock state and output valid; takes priority over a transfer.
- `in_data`  input  8  scrambled byte; bit 0 is the earliest bit on the line.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  the block accepts `in_data` this cycle.
- `out_data`  output  8  descrambled byte.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  the consumer accepts `out_data`.
- `locked`  output  1  the history register holds 7 real received bits.
- `byte_count`  output  16  bytes emitted since reset or flush; wraps from 0xFFFF to 0x0000.

## Operation
- **History:** `hist[6:0]` holds the last 7 received scrambled bits. `hist[0]` is the most recent bit.
- **Descramble rule:** for received bit stream s, the output bit is d[n] = s[n] ^ s[n-4] ^ s[n-7].
  - Positions before the stream start read from `hist`.
  - All 8 bits of a byte are computed combinationally in one cycle.
- **History update:** on an accept, `hist` shifts in all 8 bits of `in_data` (bit 7 ends up as `hist[0]`). History depends only on received data, never on output data.
- **Accept condition:** `in_valid && in_ready`, where `in_ready = !out_valid || out_ready`. `in_ready` is combinational.
- **Output register:** loaded on an accept. `out_valid` rises unless the byte is being dropped. It falls on `out_ready` with no new accept.
- **States:**
  - `UNLOCKED`: go to `LOCKED` on the first accept. That byte is dropped if `DROP_FIRST` = 1, otherwise emitted unmodified by lock state, since the zero history is used.
  - `LOCKED`: every accept is emitted.
  - `flush` returns to `UNLOCKED`.
- **`locked`** = (state == `LOCKED`).
- **`byte_count`** increments on each output handshake (`out_valid && out_ready`).
- **Simultaneous events:**
  - An output handshake and a new accept in the same cycle: the register reloads and `out_valid` stays 1 with no bubble.
  - `flush` together with an accept: the flush wins and the input byte is discarded. `in_ready` still reads 1, and the upstream source is expected to re-send.

## Timing
- Reset values: `in_ready` = 1, `out_data` = 0x00, `out_valid` = 0, `locked` = 0, `byte_count` = 0, `hist` = 0, state = `UNLOCKED`.
- Latency: accept at edge N gives `out_valid` = 1 after edge N, i.e. visible in cycle N+1.
- Throughput: 1 byte/cycle with `out_ready` held at 1.
- Backpressure: while `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0 and `out_data` is held stable.
- Reset asserted mid-stream clears everything immediately, without waiting for a clock. The first byte after release is treated as the first byte of a new stream.

## Structure
- Shared package/header holds `TAP_A` = 4, `TAP_B` = 7, `HIST_W` = 7 and the state encodings `UNLOCKED` = 1'b0, `LOCKED` = 1'b1.
- One sub-module, `descramble_byte`: purely combinational; inputs `hist[6:0]` and `in_data[7:0]`; outputs the 8 descrambled bits and the next `hist`.
- Top level holds the state register, output register, handshake logic and counter.

## Test plan
- **Zero history:** reset, `DROP_FIRST` = 0, send 0x11 → `out_data` = 0x81 one cycle later; `locked` = 1. Then send 0x00 → `out_data` = 0x09; `byte_count` = 2 after both handshakes.
- **Drop first:** `DROP_FIRST` = 1, send 0x11 then 0x00 → only 0x09 is emitted; `byte_count` = 1; `locked` = 1 after the first accept.
- **Backpressure:** hold `out_ready` = 0 for 3 cycles with `in_valid` = 1 → `in_ready` = 0 and `out_data` stable. Release → one byte/cycle with no loss or duplication.
- **Loopback:** a scrambler reference model feeds 256 random bytes, starting from a zero history matched to the descrambler, with random `out_ready` → every emitted byte matches the source sequence.
- **Flush and reset:** `flush` while `out_valid` = 1 → next cycle `out_valid` = 0, `locked` = 0, `byte_count` = 0. Async `reset` mid-burst → all outputs reach their reset values without a clock edge.
- **Counter wrap:** preload to 0xFFFF via force, one handshake → `byte_count` = 0x0000.
